sram_port_arbiter: RTL

SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

---
 rtl/sram_port_arbiter.sv | 98 +++++++++
 1 files changed

// File: rtl/sram_port_arbiter.sv
// Two-requester arbiter sharing one single-port RAM, two-stage pipeline with per-requester read return.
// Define SRAM_ARB_FIXED_PRIO_EN to make r0 always win contention instead of round-robin.
module sram_port_arbiter #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              r0_valid,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_din,
    output logic              r0_ready,
    output logic              r0_rvalid,
    output logic [DATA_W-1:0] r0_rdata,
    input  logic              r1_valid,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_din,
    output logic              r1_ready,
    output logic              r1_rvalid,
    output logic [DATA_W-1:0] r1_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    logic gnt0;
    logic gnt1;
    logic xfer;
    logic s1_read;
    logic s1_owner;

`ifdef SRAM_ARB_FIXED_PRIO_EN
    always_comb begin
        gnt0 = r0_valid;
        gnt1 = r1_valid & ~r0_valid;
    end
`else
    // last_grant=1 means r1 won most recently, so r0 takes the next contention.
    logic last_grant;

    always_comb begin
        gnt0 = r0_valid & (~r1_valid | last_grant);
        gnt1 = r1_valid & ~gnt0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (gnt0 | gnt1) begin
            last_grant <= gnt1;
        end
    end
`endif

    assign r0_ready = gnt0 & ~rst;
    assign r1_ready = gnt1 & ~rst;
    assign xfer     = gnt0 | gnt1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_en   <= 1'b0;
            ram_we   <= 1'b0;
            ram_addr <= '0;
            ram_din  <= '0;
            s1_read  <= 1'b0;
            s1_owner <= 1'b0;
        end else begin
            ram_en  <= xfer;
            ram_we  <= xfer & (gnt0 ? r0_we : r1_we);
            s1_read <= xfer & ~(gnt0 ? r0_we : r1_we);
            if (xfer) begin
                ram_addr <= gnt0 ? r0_addr : r1_addr;
                ram_din  <= gnt0 ? r0_din : r1_din;
                s1_owner <= gnt1;
            end
        end
    end

    // The owner bit travelling with each read steers the returned data to its requester.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r0_rvalid <= 1'b0;
            r1_rvalid <= 1'b0;
            r0_rdata  <= '0;
            r1_rdata  <= '0;
        end else begin
            r0_rvalid <= s1_read & ~s1_owner;
            r1_rvalid <= s1_read & s1_owner;
            if (s1_read & ~s1_owner) r0_rdata <= ram_dout;
            if (s1_read & s1_owner)  r1_rdata <= ram_dout;
        end
    end

endmodule
